// File: rtl/phase_event_tracker_pkg.sv
// Shared definitions for the phase event tracker: marker decode constants, phase encoding
// and the queued event record layout.
package phase_event_tracker_pkg;

  // Marker: inst[31:24] == 0x00, inst[19:0] == 0x02013, id in inst[23:20]
  localparam logic [31:0] MarkerMask  = 32'hFF0F_FFFF;
  localparam logic [31:0] MarkerMatch = 32'h0000_2013;
  localparam logic [3:0]  MaxMarkerId = 4'd9;

  localparam int unsigned CodeW      = 5;
  localparam int unsigned CodeCmtBit = 4;
  localparam int unsigned CycleW     = 64;

  typedef enum logic [2:0] {
    PhIdle  = 3'd0,
    PhTrain = 3'd1,
    PhDelay = 3'd2,
    PhTexe  = 3'd3,
    PhLeak  = 3'd4,
    PhVctm  = 3'd5
  } phase_e;

  typedef struct packed {
    logic [CodeW-1:0]  code;
    logic [CycleW-1:0] cycle;
  } evt_rec_t;

  function automatic logic is_marker(logic [31:0] inst);
    return ((inst & MarkerMask) == MarkerMatch) && (inst[23:20] <= MaxMarkerId);
  endfunction

  // Even id starts phase id/2+1, odd id ends the same phase
  function automatic phase_e marker_phase(logic [3:0] id);
    return phase_e'(id[3:1] + 3'd1);
  endfunction

  function automatic logic [CodeW-1:0] make_code(logic is_cmt, logic [3:0] id);
    logic [CodeW-1:0] code;
    code = CodeW'(id);
    code[CodeCmtBit] = is_cmt;
    return code;
  endfunction

endpackage

// File: rtl/phase_event_tracker_evt_fifo.sv
// Two-write / one-read synchronous FIFO. Writes are pre-compacted by the caller: wr_cnt_i
// entries taken from wr0 then wr1; the caller never writes more than free_cnt_o plus a pop.
module evt_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       wr_cnt_i,
  input  logic [Width-1:0] wr0_data_i,
  input  logic [Width-1:0] wr1_data_i,
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output logic [Width-1:0] rd_data_o,
  output logic [CntW-1:0]  free_cnt_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW-1:0]  wptr_nxt;
  logic [CntW-1:0]  cnt_q;
  logic             pop;

  assign pop        = rd_en_i && (cnt_q != '0);
  assign wptr_nxt   = wptr_q + PtrW'(1);
  assign rd_valid_o = (cnt_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;
  assign free_cnt_o = CntW'(Depth) - cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      wptr_q <= wptr_q + PtrW'(wr_cnt_i);
      cnt_q  <= cnt_q + CntW'(wr_cnt_i) - CntW'(pop);
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count
  always_ff @(posedge clock) begin
    if (reset && (wr_cnt_i != 2'd0)) mem_q[wptr_q] <= wr0_data_i;
    if (reset && (wr_cnt_i == 2'd2)) mem_q[wptr_nxt] <= wr1_data_i;
  end

endmodule

// File: rtl/phase_event_tracker.sv
// Decodes dispatch/commit marker instructions, timestamps them into an event FIFO and
// tracks the committed attack phase with a sticky ordering-error flag.
module phase_event_tracker
  import phase_event_tracker_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAINT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enq_valid_i,
  input  logic [31:0]        enq_inst_i,
  input  logic               cmt_valid_i,
  input  logic [31:0]        cmt_inst_i,
  input  logic [TAINT_W-1:0] taint_sum_i,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [4:0]         evt_code_o,
  output logic [63:0]        evt_cycle_o,
  output logic [TAINT_W-1:0] evt_taint_o,
  output logic [2:0]         phase_o,
  output logic [15:0]        drop_cnt_o,
  output logic               seq_error_o
);

  localparam int unsigned RecW = $bits(evt_rec_t) + TAINT_W;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [63:0]     cycle_q;
  phase_e          phase_q, phase_d, cmt_phase;
  logic            seq_error_q, seq_error_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [16:0]     drop_sum;
  logic            disp_hit, cmt_hit, pop;
  logic [3:0]      cmt_id;
  evt_rec_t        disp_rec, cmt_rec, head_rec;
  logic [RecW-1:0] disp_word, cmt_word, wr0_data, wr1_data, rd_data;
  logic [1:0]      wr_cnt, n_drop;
  logic [CntW-1:0] free_cnt;
  logic [CntW:0]   avail;

  assign disp_hit  = enq_valid_i && is_marker(enq_inst_i);
  assign cmt_hit   = cmt_valid_i && is_marker(cmt_inst_i);
  assign cmt_id    = cmt_inst_i[23:20];
  assign cmt_phase = marker_phase(cmt_id);

  assign disp_rec  = '{code: make_code(1'b0, enq_inst_i[23:20]), cycle: cycle_q};
  assign cmt_rec   = '{code: make_code(1'b1, cmt_id), cycle: cycle_q};
  assign disp_word = {taint_sum_i, disp_rec};
  assign cmt_word  = {taint_sum_i, cmt_rec};
  assign pop       = evt_valid_o && evt_ready_i;

  // Slots freed by this cycle's pop are usable by this cycle's pushes
  always_comb begin
    avail    = {1'b0, free_cnt} + (CntW + 1)'(pop);
    wr_cnt   = 2'd0;
    n_drop   = 2'd0;
    wr0_data = disp_word;
    wr1_data = cmt_word;
    case ({disp_hit, cmt_hit})
      2'b11: begin
        if (avail >= (CntW + 1)'(2)) begin
          wr_cnt = 2'd2;
        end else if (avail == (CntW + 1)'(1)) begin
          wr_cnt = 2'd1;
          n_drop = 2'd1;
        end else begin
          n_drop = 2'd2;
        end
      end
      2'b10, 2'b01: begin
        if (cmt_hit) wr0_data = cmt_word;
        if (avail != '0) wr_cnt = 2'd1;
        else             n_drop = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    phase_d     = phase_q;
    seq_error_d = seq_error_q;
    if (cmt_hit) begin
      if (!cmt_id[0]) begin
        if (phase_q == PhIdle) begin
          phase_d = cmt_phase;
        end else begin
          phase_d     = PhIdle;
          seq_error_d = 1'b1;
        end
      end else begin
        phase_d = PhIdle;
        if (phase_q != cmt_phase) seq_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_q     <= '0;
      phase_q     <= PhIdle;
      seq_error_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      cycle_q     <= cycle_q + 64'd1;
      phase_q     <= phase_d;
      seq_error_q <= seq_error_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  evt_fifo #(
    .Depth (DEPTH),
    .Width (RecW)
  ) u_evt_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_cnt_i   (wr_cnt),
    .wr0_data_i (wr0_data),
    .wr1_data_i (wr1_data),
    .rd_en_i    (evt_ready_i),
    .rd_valid_o (evt_valid_o),
    .rd_data_o  (rd_data),
    .free_cnt_o (free_cnt)
  );

  assign head_rec    = evt_rec_t'(rd_data[$bits(evt_rec_t)-1:0]);
  assign evt_code_o  = head_rec.code;
  assign evt_cycle_o = head_rec.cycle;
  assign evt_taint_o = rd_data[RecW-1 -: TAINT_W];
  assign phase_o     = phase_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign seq_error_o = seq_error_q;

endmodule

// File: tb/tb_phase_event_tracker.sv
// Directed bench for phase_event_tracker: phase sequencing, dual-event ordering,
// overflow/drop accounting, sequence errors and mid-run reset.
module tb_phase_event_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid, cmt_valid, evt_ready;
  logic [31:0] enq_inst, cmt_inst, taint_sum;
  logic        evt_valid, seq_error;
  logic [4:0]  evt_code;
  logic [63:0] evt_cycle;
  logic [31:0] evt_taint;
  logic [2:0]  phase;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  longint unsigned cyc = 0;
  longint unsigned t0;

  always #5 clock = ~clock;

  phase_event_tracker #(
    .DEPTH   (8),
    .TAINT_W (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enq_valid_i (enq_valid),
    .enq_inst_i  (enq_inst),
    .cmt_valid_i (cmt_valid),
    .cmt_inst_i  (cmt_inst),
    .taint_sum_i (taint_sum),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_code_o  (evt_code),
    .evt_cycle_o (evt_cycle),
    .evt_taint_o (evt_taint),
    .phase_o     (phase),
    .drop_cnt_o  (drop_cnt),
    .seq_error_o (seq_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic clear_in();
    enq_valid = 1'b0;
    cmt_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; evt_ready = 1'b0; taint_sum = '0;
    enq_valid = 1'b0; cmt_valid = 1'b0; enq_inst = '0; cmt_inst = '0;
    step(); step();
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_seqerr", 64'(seq_error), 64'd0);
    check("rst_code", 64'(evt_code), 64'd0);
    check("rst_cycle", evt_cycle, 64'd0);
    check("rst_taint", 64'(evt_taint), 64'd0);

    // Release: the current cycle is cycle 0
    reset = 1'b1; cyc = 0;
    evt_ready = 1'b1;
    cmt_valid = 1'b1; cmt_inst = 32'h0000_2013; taint_sum = 32'hAAAA_0001;
    step();
    check("train_phase", 64'(phase), 64'd1);
    check("train_valid", 64'(evt_valid), 64'd1);
    check("train_code", 64'(evt_code), 64'h10);
    check("train_cycle", evt_cycle, 64'd0);
    check("train_taint", 64'(evt_taint), 64'hAAAA_0001);
    cmt_inst = 32'h0010_2013; taint_sum = 32'hBBBB_0002;
    step();
    check("end_phase", 64'(phase), 64'd0);
    check("end_code", 64'(evt_code), 64'h11);
    check("end_cycle", evt_cycle, 64'd1);
    check("end_taint", 64'(evt_taint), 64'hBBBB_0002);
    check("end_seqerr", 64'(seq_error), 64'd0);
    clear_in();
    step();
    check("drain_valid", 64'(evt_valid), 64'd0);

    // Same-cycle dispatch and commit: dispatch first, shared stamp
    evt_ready = 1'b0; t0 = cyc;
    enq_valid = 1'b1; enq_inst = 32'h0040_2013;
    cmt_valid = 1'b1; cmt_inst = 32'h0040_2013; taint_sum = 32'h1234_5678;
    step();
    clear_in();
    check("dual_code0", 64'(evt_code), 64'h04);
    check("dual_cycle0", evt_cycle, t0);
    check("dual_phase", 64'(phase), 64'd3);
    check("dual_stable", 64'(evt_code), 64'h04);
    evt_ready = 1'b1;
    step();
    check("dual_code1", 64'(evt_code), 64'h14);
    check("dual_cycle1", evt_cycle, t0);
    check("dual_taint1", 64'(evt_taint), 64'h1234_5678);
    cmt_valid = 1'b1; cmt_inst = 32'h0050_2013;
    step();
    clear_in();
    check("texe_end_phase", 64'(phase), 64'd0);
    check("texe_end_code", 64'(evt_code), 64'h15);
    step();
    check("dual_empty", 64'(evt_valid), 64'd0);

    // Overflow: 9 single events into 8 entries
    evt_ready = 1'b0; t0 = cyc;
    for (int i = 0; i < 9; i++) begin
      enq_valid = 1'b1; enq_inst = 32'h0000_2013;
      step();
    end
    clear_in();
    check("ovf_drop1", 64'(drop_cnt), 64'd1);
    check("ovf_valid", 64'(evt_valid), 64'd1);
    check("ovf_head_cycle", evt_cycle, t0);
    enq_valid = 1'b1; enq_inst = 32'h0000_2013;
    cmt_valid = 1'b1; cmt_inst = 32'h0000_2013;
    step();
    clear_in();
    check("full_dual_drop", 64'(drop_cnt), 64'd3);
    check("full_dual_phase", 64'(phase), 64'd1);

    // START while in TRAIN is illegal; event dropped since the FIFO is full
    cmt_valid = 1'b1; cmt_inst = 32'h0020_2013;
    step();
    clear_in();
    check("seq_err_set", 64'(seq_error), 64'd1);
    check("seq_err_phase", 64'(phase), 64'd0);
    check("seq_err_drop", 64'(drop_cnt), 64'd4);
    cmt_valid = 1'b1; cmt_inst = 32'h00A0_2013;
    step();
    clear_in();
    check("id10_drop", 64'(drop_cnt), 64'd4);
    check("id10_phase", 64'(phase), 64'd0);
    check("id10_seqerr", 64'(seq_error), 64'd1);

    // Full FIFO with a pop: one slot for two events, commit is dropped
    evt_ready = 1'b1;
    enq_valid = 1'b1; enq_inst = 32'h0020_2013;
    cmt_valid = 1'b1; cmt_inst = 32'h0010_2013;
    step();
    clear_in();
    check("one_slot_drop", 64'(drop_cnt), 64'd5);
    check("one_slot_head", evt_cycle, t0 + 1);
    for (int i = 0; i < 7; i++) step();
    check("one_slot_last", 64'(evt_code), 64'h02);
    step();
    check("one_slot_empty", 64'(evt_valid), 64'd0);
    check("one_slot_seqerr", 64'(seq_error), 64'd1);

    // Mid-run reset discards queued events
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1; enq_inst = 32'h0060_2013;
      step();
    end
    clear_in();
    check("pre_rst_valid", 64'(evt_valid), 64'd1);
    reset = 1'b0;
    step();
    check("mid_rst_valid", 64'(evt_valid), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    check("mid_rst_seqerr", 64'(seq_error), 64'd0);
    check("mid_rst_code", 64'(evt_code), 64'd0);
    reset = 1'b1; cyc = 0;
    enq_valid = 1'b1; enq_inst = 32'h0080_2013; taint_sum = 32'h0000_CAFE;
    step();
    clear_in();
    check("post_rst_code", 64'(evt_code), 64'h08);
    check("post_rst_cycle", evt_cycle, 64'd0);
    check("post_rst_taint", 64'(evt_taint), 64'h0000_CAFE);
    check("post_rst_phase", 64'(phase), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
